vxc_mul3_add: RTL and testbench
===============================

VXC_MUL3_ADD -- requirements
Module: vxc_mul3_add

Interface
REQ-001 Parameter no_of_units, default 8: number of 32-bit lanes processed per chunk.
REQ-002 Parameter element_width, default 32: lane width, IEEE-754 single precision.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high; clock clk.
REQ-005 total  in  32  number of vector elements; chunk count N = total / no_of_units, integer division.
REQ-006 vec_in  in  element_width*no_of_units  vector operand a; lane i is bits [32*(i+1)-1 : 32*i].
REQ-007 scalar  in  element_width  FP scalar c; held stable while reset is low.
REQ-008 addend_in  in  element_width*no_of_units  vector operand b, same lane packing as vec_in.
REQ-009 sub  in  1  0: result = b + c*a; 1: result = b - c*a.
REQ-010 finish  out  1  level; all N chunks written.
REQ-011 result_mem_we  out  1  one-cycle write strobe; result valid in that cycle.
REQ-012 result  out  element_width*no_of_units  per-lane results.
REQ-013 read_again  out  1  one-cycle request for the next chunk of vec_in/addend_in.

Function
REQ-014 The FSM SHALL have states REQ, LOAD, MUL, ADD, WR, DONE, advancing one state per clock.
REQ-015 On leaving reset, the FSM SHALL enter REQ if N>0, otherwise DONE.
REQ-016 REQ SHALL assert read_again for exactly one cycle.
REQ-017 LOAD SHALL capture vec_in and addend_in in the cycle after the read_again cycle, matching the 1-cycle memory read latency.
REQ-018 MUL SHALL register p_i = c*a_i per lane; when sub=1, the sign of p_i SHALL be inverted.
REQ-019 ADD SHALL register r_i = b_i + p_i per lane.
REQ-020 WR SHALL drive result = r and assert result_mem_we for exactly one cycle, then increment the chunk counter.
REQ-021 After WR, the FSM SHALL go to REQ if count < N, else to DONE.
REQ-022 DONE SHALL hold finish=1, read_again=0 and result_mem_we=0 until reset.
REQ-023 Per-chunk latency SHALL be 5 cycles: read_again at cycle t, result_mem_we at t+4.
REQ-024 Total duration SHALL be 5N cycles from reset release to the last write; finish SHALL rise the cycle after the last write.
REQ-025 Arithmetic rules:
- IEEE-754 single precision, round toward zero.
- Denormal inputs and results flushed to +0.
- Exponent overflow saturates to signed infinity.
- NaN/inf inputs are not required to propagate.
REQ-026 An exact-zero sum SHALL give +0.
REQ-027 A zero product SHALL give result equal to b, bit-exact except that -0 becomes +0.
REQ-028 result SHALL hold its last written value between WR states.
REQ-029 total, scalar and sub are sampled continuously; changes while reset is low give undefined results and are not required to be detected.

Reset
REQ-030 While reset=1, the FSM SHALL be forced to REQ-pending idle with count=0.
REQ-031 Reset values: finish=0, read_again=0, result_mem_we=0, result=0.
REQ-032 Reset asserted mid-operation SHALL abort within one cycle and restart from chunk 0 on release.
REQ-033 Reset SHALL be the only way to clear finish or to start a new pass.

Structure
REQ-034 A shared package SHALL hold:
- FP32 field widths (sign 1, exponent 8, mantissa 23) and the exponent bias 127.
- The FSM state enum.
- The lane-slice width constant.
REQ-035 One sub-module, fp32_mul_add_lane, SHALL implement the per-lane multiply-then-add with the two pipeline registers.
REQ-036 The top SHALL instantiate fp32_mul_add_lane no_of_units times via generate.
REQ-037 The top SHALL contain only the FSM, the chunk counter and the input capture registers.

Verification
REQ-038 Add: total=8, sub=0, c=0x40000000 (2.0), all a=0x3F800000 (1.0), all b=0x3F800000 -> one write with every lane 0x40400000 (3.0); finish rises 6 cycles after reset release.
REQ-039 Subtract: as REQ-038 with sub=1 -> every lane 0xBF800000 (-1.0).
REQ-040 Multi-chunk: total=24, c=0x3F000000 (0.5), a=0x40800000 (4.0), b=0 -> 3 read_again pulses and 3 result_mem_we pulses 5 cycles apart; every lane 0x40000000.
REQ-041 Zero cases:
- total=0 -> finish=1 the cycle after reset release, with no read_again or result_mem_we.
- c=0 -> every result lane equals b.
REQ-042 Reset mid-operation: total=16, reset asserted during ADD of chunk 0 -> all outputs 0 next cycle; after release, 2 full chunks then finish.

Source files
------------

// File: rtl/vxc_mul3_add_pkg.sv
// Shared FP32 field layout and controller state encoding for the
// vector fused scale-and-add engine.
package vxc_mul3_add_pkg;
   localparam int SIGN_W   = 1;
   localparam int EXP_W    = 8;
   localparam int MAN_W    = 23;
   localparam int EXP_BIAS = 127;
   localparam int LANE_W   = SIGN_W + EXP_W + MAN_W;

   // S_IDLE is the reset-held, request-pending state; it leaves on the first un-reset edge.
   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_LOAD, S_MUL, S_ADD, S_WR, S_DONE
   } state_e;
endpackage

// File: rtl/fp32_mul_add_lane.sv
// One lane of r = b +/- c*a in FP32: round toward zero, denormals flushed
// to +0, overflow saturates to signed infinity. Product and sum registered.
module fp32_mul_add_lane
   import vxc_mul3_add_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              mul_en_i,
   input  logic              add_en_i,
   input  logic              sub_i,
   input  logic [LANE_W-1:0] a_i,
   input  logic [LANE_W-1:0] b_i,
   input  logic [LANE_W-1:0] c_i,
   output logic [LANE_W-1:0] r_o
);

   logic [LANE_W-1:0] p_q, r_q;

   function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
      logic [47:0]       prod;
      logic [22:0]       man;
      logic signed [9:0] e;
      prod = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
      e    = $signed({2'b00, x[30:23]}) + $signed({2'b00, y[30:23]}) - 10'(EXP_BIAS);
      if (prod[47]) begin
         man = prod[46:24];
         e   = e + 10'sd1;
      end else begin
         man = prod[45:23];
      end
      if (x[30:23] == 8'd0 || y[30:23] == 8'd0 || e <= 10'sd0) fp_mul = '0;
      else if (e >= 10'sd255) fp_mul = {x[31] ^ y[31], 8'hFF, 23'd0};
      else fp_mul = {x[31] ^ y[31], e[7:0], man};
   endfunction

   // 27-bit significand path: hidden bit, 23 fraction, guard/round/sticky,
   // so that plain truncation after normalisation is a correct round-to-zero.
   function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
      logic [31:0]       big, sml;
      logic [27:0]       mb, ms, sum;
      logic [7:0]        d;
      logic signed [9:0] e;
      logic              sticky;
      if (x[30:23] == 8'd0) return (y[30:23] == 8'd0) ? 32'd0 : y;
      if (y[30:23] == 8'd0) return x;
      if (x[30:0] >= y[30:0]) begin
         big = x; sml = y;
      end else begin
         big = y; sml = x;
      end
      d  = big[30:23] - sml[30:23];
      mb = {2'b01, big[22:0], 3'b000};
      ms = {2'b01, sml[22:0], 3'b000};
      if (d >= 8'd27) begin
         ms = 28'd1;
      end else begin
         sticky = |(ms & ((28'd1 << d) - 28'd1));
         ms     = (ms >> d) | {27'd0, sticky};
      end
      sum = (big[31] == sml[31]) ? mb + ms : mb - ms;
      if (sum == 28'd0) return 32'd0;
      e = $signed({2'b00, big[30:23]});
      if (sum[27]) begin
         sum = {1'b0, sum[27:2], sum[1] | sum[0]};
         e   = e + 10'sd1;
      end else begin
         for (int i = 0; i < 26; i++) begin
            if (!sum[26]) begin
               sum = sum << 1;
               e   = e - 10'sd1;
            end
         end
      end
      if (e <= 10'sd0) return 32'd0;
      if (e >= 10'sd255) return {big[31], 8'hFF, 23'd0};
      return {big[31], e[7:0], sum[25:3]};
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         p_q <= '0;
         r_q <= '0;
      end else begin
         if (mul_en_i) p_q <= fp_mul(c_i, a_i) ^ {sub_i, 31'd0};
         if (add_en_i) r_q <= fp_add(b_i, p_q);
      end
   end

   assign r_o = r_q;

endmodule

// File: rtl/vxc_mul3_add.sv
// Chunked vector engine: requests a chunk, captures it, runs every lane
// through multiply then add, and strobes the result out; 5 cycles per chunk.
module vxc_mul3_add
   import vxc_mul3_add_pkg::*;
#(
   parameter int no_of_units   = 8,
   parameter int element_width = 32
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [31:0]                          total,
   input  logic [element_width*no_of_units-1:0] vec_in,
   input  logic [element_width-1:0]             scalar,
   input  logic [element_width*no_of_units-1:0] addend_in,
   input  logic                                 sub,
   output logic                                 finish,
   output logic                                 result_mem_we,
   output logic [element_width*no_of_units-1:0] result,
   output logic                                 read_again
);

   state_e                               state_q;
   logic [31:0]                          cnt_q, n_chunks;
   logic                                 rd_q, we_q, fin_q;
   logic [element_width*no_of_units-1:0] a_q, b_q;
   logic                                 mul_en, add_en;

   assign n_chunks = total / 32'(no_of_units);
   assign mul_en   = (state_q == S_MUL);
   assign add_en   = (state_q == S_ADD);

   // Outputs are registered on entry to the state that owns them, so
   // read_again is high in REQ and result_mem_we is high in WR.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rd_q    <= 1'b0;
         we_q    <= 1'b0;
         fin_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (n_chunks != 32'd0) begin
                  state_q <= S_REQ;
                  rd_q    <= 1'b1;
               end else begin
                  state_q <= S_DONE;
                  fin_q   <= 1'b1;
               end
            end
            S_REQ: begin
               rd_q    <= 1'b0;
               state_q <= S_LOAD;
            end
            S_LOAD: begin
               a_q     <= vec_in;
               b_q     <= addend_in;
               state_q <= S_MUL;
            end
            S_MUL: state_q <= S_ADD;
            S_ADD: begin
               we_q    <= 1'b1;
               state_q <= S_WR;
            end
            S_WR: begin
               we_q  <= 1'b0;
               cnt_q <= cnt_q + 32'd1;
               if (cnt_q + 32'd1 < n_chunks) begin
                  state_q <= S_REQ;
                  rd_q    <= 1'b1;
               end else begin
                  state_q <= S_DONE;
                  fin_q   <= 1'b1;
               end
            end
            S_DONE:  state_q <= S_DONE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign read_again    = rd_q;
   assign result_mem_we = we_q;
   assign finish        = fin_q;

   for (genvar i = 0; i < no_of_units; i++) begin : g_lane
      fp32_mul_add_lane u_lane (
         .clk      (clk),
         .reset    (reset),
         .mul_en_i (mul_en),
         .add_en_i (add_en),
         .sub_i    (sub),
         .a_i      (a_q[i*element_width +: element_width]),
         .b_i      (b_q[i*element_width +: element_width]),
         .c_i      (scalar),
         .r_o      (result[i*element_width +: element_width])
      );
   end

endmodule

// File: tb/tb_vxc_mul3_add.sv
// Bench for vxc_mul3_add: 1-cycle-latency memory model, real-arithmetic
// reference for b +/- c*a with round-to-zero and flush-to-zero.
module tb_vxc_mul3_add;
   localparam int NU = 8;
   localparam int EW = 32;

   logic            clk = 1'b0, reset = 1'b1, sub = 1'b0;
   logic [31:0]     total = '0;
   logic [EW-1:0]   scalar = '0;
   logic [EW*NU-1:0] vec_in = '0, addend_in = '0, result;
   logic            finish, result_mem_we, read_again;

   always #5 clk = ~clk;

   vxc_mul3_add #(.no_of_units(NU), .element_width(EW)) dut (
      .clk(clk), .reset(reset), .total(total), .vec_in(vec_in), .scalar(scalar),
      .addend_in(addend_in), .sub(sub), .finish(finish), .result_mem_we(result_mem_we),
      .result(result), .read_again(read_again)
   );

   int checks = 0, errors = 0;
   logic [31:0]      stim_a [8][8], stim_b [8][8];
   int               rd_at [8], wr_at [8];
   logic [EW*NU-1:0] wr_val [8];
   int               n_rd, n_wr, fin_at;
   logic             ab_fin, ab_rd, ab_we;
   logic [EW*NU-1:0] ab_res;

   // ---------------- reference model ----------------
   function automatic real pow2(input int k);
      real r = 1.0;
      if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
      else for (int i = 0; i < -k; i++) r = r / 2.0;
      return r;
   endfunction

   function automatic real f2r(input logic [31:0] x);
      real v;
      if (x[30:23] == 8'd0) return 0.0;
      v = (1.0 + real'(x[22:0]) / 8388608.0) * pow2(int'(x[30:23]) - 127);
      return x[31] ? -v : v;
   endfunction

   function automatic logic [31:0] r2f(input real v);
      real    m;
      int     e, be;
      longint fr;
      logic   s;
      if (v == 0.0) return 32'd0;
      s = (v < 0.0);
      m = s ? -v : v;
      e = 0;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0) begin m = m * 2.0; e--; end
      be = e + 127;
      if (be <= 0) return 32'd0;
      if (be >= 255) return {s, 8'hFF, 23'd0};
      fr = longint'($floor((m - 1.0) * 8388608.0));
      return {s, be[7:0], fr[22:0]};
   endfunction

   function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic s);
      logic [31:0] p;
      p = r2f(f2r(c) * f2r(a));
      if (s) p[31] = ~p[31];
      return r2f(f2r(b) + f2r(p));
   endfunction

   function automatic logic [31:0] rnd_fp();
      logic [31:0] r;
      r = $urandom();
      r[30:23] = 8'($urandom_range(120, 134));
      return r;
   endfunction

   // ---------------- driver / monitor ----------------
   task automatic run_pass(input int tot, input logic [31:0] c, input logic s,
                           input int max_cyc, input int abort_k);
      int   chunk;
      logic drv;
      @(negedge clk);
      reset = 1'b1; total = tot; scalar = c; sub = s;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      n_rd = 0; n_wr = 0; fin_at = -1; chunk = 0; drv = 1'b0;
      for (int k = 0; k < max_cyc; k++) begin
         @(negedge clk);
         if (read_again && n_rd < 8) begin rd_at[n_rd] = k; n_rd++; end
         if (result_mem_we && n_wr < 8) begin wr_at[n_wr] = k; wr_val[n_wr] = result; n_wr++; end
         if (finish && fin_at < 0) fin_at = k;
         // data valid only in the cycle after the read_again cycle
         for (int l = 0; l < NU; l++) begin
            vec_in[l*EW +: EW]    = (drv && chunk < 8) ? stim_a[chunk][l] : $urandom();
            addend_in[l*EW +: EW] = (drv && chunk < 8) ? stim_b[chunk][l] : $urandom();
         end
         if (drv) chunk++;
         drv = read_again;
         if (k == abort_k) begin
            reset = 1'b1;
            @(negedge clk);
            ab_fin = finish; ab_rd = read_again; ab_we = result_mem_we; ab_res = result;
            break;
         end
      end
   endtask

   task automatic fill_const(input logic [31:0] a, input logic [31:0] b);
      for (int j = 0; j < 8; j++)
         for (int l = 0; l < NU; l++) begin stim_a[j][l] = a; stim_b[j][l] = b; end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_add();
      fill_const(32'h3F800000, 32'h3F800000);
      run_pass(8, 32'h40000000, 1'b0, 20, -1);
      checks++; if (n_wr !== 1) begin errors++; $display("FAIL add_nwr got %0d want 1", n_wr); end
      checks++; if (wr_at[0] !== 4) begin errors++; $display("FAIL add_wr_cycle got %0d want 4", wr_at[0]); end
      checks++; if (n_rd !== 1 || rd_at[0] !== 0) begin errors++; $display("FAIL add_rd got n=%0d at %0d want 1 at 0", n_rd, rd_at[0]); end
      checks++; if (fin_at !== 5) begin errors++; $display("FAIL add_finish got %0d want 5", fin_at); end
      for (int l = 0; l < NU; l++) begin
         checks++;
         if (wr_val[0][l*EW +: EW] !== 32'h40400000) begin
            errors++; $display("FAIL add_lane%0d got %h want 40400000", l, wr_val[0][l*EW +: EW]);
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk); reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({finish, read_again, result_mem_we} !== 3'b000 || result !== '0) begin
         errors++; $display("FAIL reset_vals got fin=%b rd=%b we=%b res=%h want all 0",
                            finish, read_again, result_mem_we, result);
      end
   endtask

   task automatic test_sub();
      fill_const(32'h3F800000, 32'h3F800000);
      run_pass(8, 32'h40000000, 1'b1, 20, -1);
      checks++; if (n_wr !== 1 || fin_at !== 5) begin errors++; $display("FAIL sub_timing got nwr=%0d fin=%0d want 1,5", n_wr, fin_at); end
      for (int l = 0; l < NU; l++) begin
         checks++;
         if (wr_val[0][l*EW +: EW] !== 32'hBF800000) begin
            errors++; $display("FAIL sub_lane%0d got %h want bf800000", l, wr_val[0][l*EW +: EW]);
         end
      end
   endtask

   task automatic test_multi();
      fill_const(32'h40800000, 32'h00000000);
      run_pass(24, 32'h3F000000, 1'b0, 40, -1);
      checks++; if (n_rd !== 3 || n_wr !== 3) begin errors++; $display("FAIL multi_counts got rd=%0d wr=%0d want 3,3", n_rd, n_wr); end
      for (int j = 0; j < 3; j++) begin
         checks++;
         if (rd_at[j] !== 5*j || wr_at[j] !== 5*j + 4) begin
            errors++; $display("FAIL multi_cycle%0d got rd=%0d wr=%0d want %0d,%0d", j, rd_at[j], wr_at[j], 5*j, 5*j+4);
         end
         checks++;
         if (wr_val[j] !== {NU{32'h40000000}}) begin
            errors++; $display("FAIL multi_val%0d got %h want all 40000000", j, wr_val[j]);
         end
      end
      checks++; if (fin_at !== 15) begin errors++; $display("FAIL multi_finish got %0d want 15", fin_at); end
   endtask

   task automatic test_zero_total();
      int tots [2] = '{0, 7};
      foreach (tots[t]) begin
         run_pass(tots[t], 32'h40000000, 1'b0, 12, -1);
         checks++;
         if (fin_at !== 0 || n_rd !== 0 || n_wr !== 0) begin
            errors++; $display("FAIL zero_total%0d got fin=%0d rd=%0d wr=%0d want 0,0,0", tots[t], fin_at, n_rd, n_wr);
         end
      end
   endtask

   task automatic test_zero_scalar();
      logic [31:0] exp_v;
      for (int l = 0; l < NU; l++) begin stim_a[0][l] = rnd_fp(); stim_b[0][l] = rnd_fp(); end
      stim_b[0][0] = 32'h80000000;
      stim_b[0][1] = 32'h00000000;
      run_pass(8, 32'h00000000, 1'b1, 20, -1);
      for (int l = 0; l < NU; l++) begin
         exp_v = (stim_b[0][l] == 32'h80000000) ? 32'h0 : stim_b[0][l];
         checks++;
         if (n_wr !== 1 || wr_val[0][l*EW +: EW] !== exp_v) begin
            errors++; $display("FAIL zero_c_lane%0d got %h want %h", l, wr_val[0][l*EW +: EW], exp_v);
         end
      end
   endtask

   task automatic test_boundaries();
      logic [31:0] ea [8] = '{32'h3F800000, 32'h7F7FFFFF, 32'h00000001, 32'h3FC00000,
                              32'h3F800000, 32'h00800000, 32'h3FC00000, 32'h3F800001};
      logic [31:0] eb [8] = '{32'hBF800000, 32'h7F7FFFFF, 32'h40490FDB, 32'h00400000,
                              32'hB3000000, 32'h80800001, 32'h3FC00000, 32'hBF800000};
      logic [31:0] er [8] = '{32'h00000000, 32'h7F800000, 32'h40490FDB, 32'h3FC00000,
                              32'h3F7FFFFF, 32'h00000000, 32'h40400000, 32'h34000000};
      for (int l = 0; l < NU; l++) begin stim_a[0][l] = ea[l]; stim_b[0][l] = eb[l]; end
      run_pass(8, 32'h3F800000, 1'b0, 20, -1);
      for (int l = 0; l < NU; l++) begin
         checks++;
         if (n_wr !== 1 || wr_val[0][l*EW +: EW] !== er[l]) begin
            errors++; $display("FAIL edge_lane%0d got %h want %h", l, wr_val[0][l*EW +: EW], er[l]);
         end
      end
   endtask

   task automatic test_random();
      int          tot, n;
      logic [31:0] c, exp_v;
      logic        s;
      for (int it = 0; it < 6; it++) begin
         tot = $urandom_range(8, 47);
         n   = tot / NU;
         c   = rnd_fp();
         s   = 1'($urandom_range(0, 1));
         for (int j = 0; j < 8; j++)
            for (int l = 0; l < NU; l++) begin stim_a[j][l] = rnd_fp(); stim_b[j][l] = rnd_fp(); end
         run_pass(tot, c, s, 5*n + 8, -1);
         checks++;
         if (n_wr !== n || fin_at !== 5*n) begin
            errors++; $display("FAIL rand%0d_count got wr=%0d fin=%0d want %0d,%0d", it, n_wr, fin_at, n, 5*n);
         end
         for (int j = 0; j < n && j < n_wr; j++)
            for (int l = 0; l < NU; l++) begin
               exp_v = model(stim_a[j][l], stim_b[j][l], c, s);
               checks++;
               if (wr_val[j][l*EW +: EW] !== exp_v) begin
                  errors++; $display("FAIL rand%0d_c%0d_l%0d got %h want %h", it, j, l, wr_val[j][l*EW +: EW], exp_v);
               end
            end
      end
   endtask

   task automatic test_abort(input int abort_k);
      fill_const(32'h3F800000, 32'h3F800000);
      run_pass(16, 32'h40000000, 1'b0, 30, abort_k);
      checks++;
      if ({ab_fin, ab_rd, ab_we} !== 3'b000 || ab_res !== '0) begin
         errors++; $display("FAIL abort%0d_outputs got fin=%b rd=%b we=%b res=%h want all 0",
                            abort_k, ab_fin, ab_rd, ab_we, ab_res);
      end
      run_pass(16, 32'h40000000, 1'b0, 30, -1);
      checks++;
      if (n_wr !== 2 || wr_at[0] !== 4 || wr_at[1] !== 9 || fin_at !== 10) begin
         errors++; $display("FAIL abort%0d_restart got wr=%0d at %0d,%0d fin=%0d want 2 at 4,9 fin 10",
                            abort_k, n_wr, wr_at[0], wr_at[1], fin_at);
      end
      checks++;
      if (wr_val[0] !== {NU{32'h40400000}} || wr_val[1] !== {NU{32'h40400000}}) begin
         errors++; $display("FAIL abort%0d_vals got %h want all 40400000", abort_k, wr_val[1]);
      end
   endtask

   initial begin
      test_add();
      test_reset();
      test_sub();
      test_multi();
      test_zero_total();
      test_zero_scalar();
      test_boundaries();
      test_random();
      test_abort(3);
      test_abort(8);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
